// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcode encodings and default widths.
package alu_pkg;
  localparam int ALU_DATA_W = 32;
  localparam int ALU_TAG_W = 4;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;
  localparam logic [2:0] ALU_ILL = 3'b110;
  localparam logic [2:0] ALU_PASS = 3'b111;
endpackage

// File: rtl/alu_share_arb_if.sv
// alu_share_arb_if: request/response handshake bundle for the shared ALU.
// Carries rsp*_err only when ALU_ILLEGAL_OP_TRAP_EN is defined.
interface alu_share_arb_if import alu_pkg::*; #(
  parameter int DATA_W = ALU_DATA_W,
  parameter int TAG_W = ALU_TAG_W
) ();
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [2:0] req0_op, req1_op;
  logic [DATA_W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [TAG_W-1:0] req0_tag, req1_tag;
  logic rsp0_valid, rsp0_ready, rsp0_bcond, rsp1_valid, rsp1_ready, rsp1_bcond;
  logic [DATA_W-1:0] rsp0_result, rsp1_result;
  logic [TAG_W-1:0] rsp0_tag, rsp1_tag;
`ifdef ALU_ILLEGAL_OP_TRAP_EN
  logic rsp0_err, rsp1_err;
`endif
  modport slave (
    input req0_valid, req0_op, req0_a, req0_b, req0_tag,
    input req1_valid, req1_op, req1_a, req1_b, req1_tag,
    input rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_result, rsp0_bcond, rsp0_tag,
`ifdef ALU_ILLEGAL_OP_TRAP_EN
    output rsp0_err, rsp1_err,
`endif
    output rsp1_valid, rsp1_result, rsp1_bcond, rsp1_tag
  );
  modport master (
    output req0_valid, req0_op, req0_a, req0_b, req0_tag,
    output req1_valid, req1_op, req1_a, req1_b, req1_tag,
    output rsp0_ready, rsp1_ready,
    input req0_ready, req1_ready,
    input rsp0_valid, rsp0_result, rsp0_bcond, rsp0_tag,
`ifdef ALU_ILLEGAL_OP_TRAP_EN
    input rsp0_err, rsp1_err,
`endif
    input rsp1_valid, rsp1_result, rsp1_bcond, rsp1_tag
  );
endinterface

// File: rtl/alu.sv
// alu: purely combinational 32-bit ALU; slt is an unsigned compare, op 110 yields 0.
module alu import alu_pkg::*; #(
  parameter int DATA_W = ALU_DATA_W
) (
  input  logic [2:0]        i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_result,
  output logic              o_bcond
);
  always_comb begin
    o_result = '0;
    case (i_op)
      ALU_ADD:  o_result = i_a + i_b;
      ALU_SUB:  o_result = i_a - i_b;
      ALU_AND:  o_result = i_a & i_b;
      ALU_OR:   o_result = i_a | i_b;
      ALU_SLT:  o_result = {{(DATA_W-1){1'b0}}, i_a < i_b};
      ALU_XOR:  o_result = i_a ^ i_b;
      ALU_PASS: o_result = i_a;
      default:  o_result = '0;
    endcase
  end
  assign o_bcond = i_a == i_b;
endmodule

// File: rtl/alu_rr_arb2.sv
// alu_rr_arb2: two-way round-robin arbiter; rr_last resets to 1 so requester 0 wins the first tie.
module alu_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_eligible,
  output logic [1:0] o_grant
);
  logic r_rr_last;
  always_comb o_grant = (&i_eligible) ? (r_rr_last ? 2'b01 : 2'b10) : i_eligible;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_rr_last <= 1'b1;
    else if (|o_grant) r_rr_last <= o_grant[1];
endmodule

// File: rtl/alu_share_arb.sv
// alu_share_arb: shares one ALU between two requesters with round-robin grant and per-channel response buffers.
// Define ALU_ILLEGAL_OP_TRAP_EN to add rsp*_err flags for op 110.
module alu_share_arb import alu_pkg::*; #(
  parameter int DATA_W = ALU_DATA_W,
  parameter int TAG_W = ALU_TAG_W
) (
  input logic clk,
  input logic rst,
  alu_share_arb_if.slave bus
);
  logic [1:0] w_valid_in, w_rsp_ready, w_elig, w_grant;
  logic [1:0][2:0] w_op;
  logic [1:0][DATA_W-1:0] w_a, w_b;
  logic [1:0][TAG_W-1:0] w_tag;
  logic w_sel, w_bcond;
  logic [DATA_W-1:0] w_result;
  logic [1:0] r_valid, r_bcond;
  logic [1:0][DATA_W-1:0] r_result;
  logic [1:0][TAG_W-1:0] r_tag;
  assign w_valid_in = {bus.req1_valid, bus.req0_valid};
  assign w_rsp_ready = {bus.rsp1_ready, bus.rsp0_ready};
  assign w_op = {bus.req1_op, bus.req0_op};
  assign w_a = {bus.req1_a, bus.req0_a};
  assign w_b = {bus.req1_b, bus.req0_b};
  assign w_tag = {bus.req1_tag, bus.req0_tag};
  // A full buffer being drained this cycle can accept a new result on the same edge.
  assign w_elig = w_valid_in & (~r_valid | w_rsp_ready);
  assign w_sel = w_grant[1];
  alu_rr_arb2 u_arb (
    .clk(clk),
    .rst(rst),
    .i_eligible(w_elig),
    .o_grant(w_grant)
  );
  alu #(.DATA_W(DATA_W)) u_alu (
    .i_op(w_op[w_sel]),
    .i_a(w_a[w_sel]),
    .i_b(w_b[w_sel]),
    .o_result(w_result),
    .o_bcond(w_bcond)
  );
`ifdef ALU_ILLEGAL_OP_TRAP_EN
  logic [1:0] r_err;
  logic w_ill;
  assign w_ill = w_op[w_sel] == ALU_ILL;
  assign bus.rsp0_err = r_err[0];
  assign bus.rsp1_err = r_err[1];
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_valid <= '0;
      r_result <= '0;
      r_bcond <= '0;
      r_tag <= '0;
`ifdef ALU_ILLEGAL_OP_TRAP_EN
      r_err <= '0;
`endif
    end else begin
      for (int k = 0; k < 2; k++)
        if (w_grant[k]) begin
          r_valid[k] <= 1'b1;
          r_result[k] <= w_result;
          r_bcond[k] <= w_bcond;
          r_tag[k] <= w_tag[k];
`ifdef ALU_ILLEGAL_OP_TRAP_EN
          r_err[k] <= w_ill;
`endif
        end else if (w_rsp_ready[k]) r_valid[k] <= 1'b0;
    end
  assign bus.req0_ready = w_grant[0];
  assign bus.req1_ready = w_grant[1];
  assign bus.rsp0_valid = r_valid[0];
  assign bus.rsp1_valid = r_valid[1];
  assign bus.rsp0_result = r_result[0];
  assign bus.rsp1_result = r_result[1];
  assign bus.rsp0_bcond = r_bcond[0];
  assign bus.rsp1_bcond = r_bcond[1];
  assign bus.rsp0_tag = r_tag[0];
  assign bus.rsp1_tag = r_tag[1];
endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: directed self-checking bench for alu_share_arb.
module tb_alu_share_arb;
  logic clk, rst;
  int checks = 0, errors = 0;
  alu_share_arb_if #(.DATA_W(32), .TAG_W(4)) bus ();
  alu_share_arb #(.DATA_W(32), .TAG_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_inputs();
    bus.req0_valid = 0; bus.req0_op = 0; bus.req0_a = 0; bus.req0_b = 0; bus.req0_tag = 0;
    bus.req1_valid = 0; bus.req1_op = 0; bus.req1_a = 0; bus.req1_b = 0; bus.req1_tag = 0;
    bus.rsp0_ready = 1; bus.rsp1_ready = 1;
  endtask
  task automatic do_reset();
    rst = 1;
    tick();
    tick();
    rst = 0;
    tick();
  endtask
  task automatic op0(input string nm, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] res, input logic bc, input logic err);
    bus.req0_valid = 1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b; bus.req0_tag = op + 4'd1;
    #1;
    check({nm, "_ready"}, bus.req0_ready, 1);
    tick();
    bus.req0_valid = 0;
    check({nm, "_res"}, {bus.rsp0_valid, bus.rsp0_tag, bus.rsp0_result}, {1'b1, 4'(op + 4'd1), res});
    check({nm, "_bcond"}, bus.rsp0_bcond, bc);
`ifdef ALU_ILLEGAL_OP_TRAP_EN
    check({nm, "_err"}, bus.rsp0_err, err);
`else
    if (err) checks = checks + 0;
`endif
  endtask
  initial begin
    idle_inputs();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      check("idle", {bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid}, 0);
      tick();
    end
    // single add on requester 0
    bus.req0_valid = 1; bus.req0_op = 3'b000; bus.req0_a = 5; bus.req0_b = 7; bus.req0_tag = 3;
    #1;
    check("add_rdy", {bus.req1_ready, bus.req0_ready}, 2'b01);
    tick();
    bus.req0_valid = 0;
    check("add_rsp", {bus.rsp0_valid, bus.rsp0_bcond, bus.rsp0_tag, bus.rsp0_result}, {2'b10, 4'd3, 32'd12});
    tick();
    check("add_drain", bus.rsp0_valid, 0);
    // round robin under contention, fresh reset so requester 0 wins first
    do_reset();
    bus.req0_valid = 1; bus.req1_valid = 1;
    bus.req0_op = 3'b000; bus.req0_a = 1; bus.req0_b = 1; bus.req0_tag = 1;
    bus.req1_op = 3'b111; bus.req1_a = 32'h77; bus.req1_b = 0; bus.req1_tag = 2;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("rr_grant", {bus.req1_ready, bus.req0_ready}, (k % 2 == 0) ? 2'b01 : 2'b10);
      tick();
      if (k % 2 == 0) check("rr_rsp0", {bus.rsp0_valid, bus.rsp0_result}, {1'b1, 32'd2});
      else check("rr_rsp1", {bus.rsp1_valid, bus.rsp1_result}, {1'b1, 32'h77});
    end
    bus.req0_valid = 0; bus.req1_valid = 0;
    tick();
    // backpressure on channel 0
    bus.rsp0_ready = 0;
    bus.req0_valid = 1; bus.req0_op = 3'b011; bus.req0_a = 32'h10; bus.req0_b = 32'h01; bus.req0_tag = 5;
    tick();
    check("bp_fill", {bus.rsp0_valid, bus.rsp0_tag, bus.rsp0_result}, {1'b1, 4'd5, 32'h11});
    bus.req0_tag = 6; bus.req0_a = 32'h20;
    bus.req1_valid = 1; bus.req1_op = 3'b010; bus.req1_a = 32'hF0; bus.req1_b = 32'h3C; bus.req1_tag = 9;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_grant", {bus.req1_ready, bus.req0_ready}, 2'b10);
      tick();
      check("bp_hold0", {bus.rsp0_valid, bus.rsp0_tag, bus.rsp0_result}, {1'b1, 4'd5, 32'h11});
      check("bp_rsp1", {bus.rsp1_valid, bus.rsp1_tag, bus.rsp1_result}, {1'b1, 4'd9, 32'h30});
    end
    bus.rsp0_ready = 1;
    #1;
    check("bp_refill_grant", {bus.req1_ready, bus.req0_ready}, 2'b01);
    tick();
    bus.req0_valid = 0; bus.req1_valid = 0;
    check("bp_refill", {bus.rsp0_valid, bus.rsp0_tag, bus.rsp0_result}, {1'b1, 4'd6, 32'h21});
    tick();
    // op semantics on requester 0
    op0("slt_u", 3'b100, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 0);
    op0("slt_1", 3'b100, 32'd1, 32'hFFFF_FFFF, 32'd1, 0, 0);
    op0("sub", 3'b001, 32'd3, 32'd5, 32'hFFFF_FFFE, 0, 0);
    op0("pass", 3'b111, 32'hDEAD, 32'd0, 32'hDEAD, 0, 0);
    op0("xor", 3'b101, 32'hA5, 32'hA5, 32'd0, 1, 0);
    op0("add_wrap", 3'b000, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 0);
    op0("and", 3'b010, 32'hF0F0, 32'hFF00, 32'hF000, 0, 0);
    op0("or", 3'b011, 32'hF0F0, 32'hFF00, 32'hFFF0, 0, 0);
    op0("illegal", 3'b110, 32'd9, 32'd9, 32'd0, 1, 1);
    op0("legal_after", 3'b000, 32'd2, 32'd9, 32'd11, 0, 0);
    tick();
    // reset while channel 1 holds a result
    bus.rsp1_ready = 0;
    bus.req1_valid = 1; bus.req1_op = 3'b000; bus.req1_a = 1; bus.req1_b = 2; bus.req1_tag = 7;
    tick();
    bus.req1_valid = 0;
    check("pre_rst", {bus.rsp1_valid, bus.rsp1_tag, bus.rsp1_result}, {1'b1, 4'd7, 32'd3});
    #2 rst = 1;
    #1;
    check("async_rst", {bus.rsp1_valid, bus.rsp1_tag, bus.rsp1_result}, 0);
    tick();
    rst = 0;
    bus.rsp1_ready = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst", {bus.rsp0_valid, bus.rsp1_valid}, 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Shares one instance of the existing 32-bit ALU between two requesters (e.g. main pipe and a multi-cycle helper unit).
- Uses valid/ready request handshakes and round-robin arbitration, one op per cycle.
- Each requester gets a one-entry registered response buffer with its own valid/ready handshake.
- Sits between the issuing units and the ALU; the ALU itself stays purely combinational.

Parameters:
- DATA_W, 32, operand/result width; must equal ALU width.
- TAG_W, 4, width of opaque request tag returned with result.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has an op
- req0_ready  out  1  requester 0 op accepted this cycle
- req0_op  in  3  aluop encoding
- req0_a  in  DATA_W  operand 1 (data1)
- req0_b  in  DATA_W  operand 2 (data2)
- req0_tag  in  TAG_W  returned unchanged
- req1_valid/ready/op/a/b/tag  same as requester 0, for requester 1
- rsp0_valid  out  1  response buffer 0 holds a result
- rsp0_ready  in  1  consumer 0 takes result
- rsp0_result  out  DATA_W  ALU result
- rsp0_bcond  out  1  1 when a==b
- rsp0_tag  out  TAG_W  tag of the op
- rsp1_valid/ready/result/bcond/tag  same as response 0, for channel 1

Behaviour:
- Reset (async, rst=1): rsp*_valid=0, rsp*_result=0, rsp*_bcond=0, rsp*_tag=0, rr_last=1 (requester 0 wins first tie).
- eligible_i = reqi_valid & (!rspi_valid | rspi_ready).
  - A full buffer being drained this cycle may be refilled in the same cycle.
- Grant:
  - Only one eligible: that one is granted.
  - Both eligible: the one != rr_last is granted.
  - Neither eligible: no grant.
  - reqi_ready = grant_i (combinational; depends on valid and rsp_ready).
  - At most one ready is high per cycle.
- On grant edge:
  - ALU is driven combinationally from the granted requester's op/a/b.
  - result, bcond and tag are registered into buffer i; rspi_valid=1.
  - rr_last=i.
- Latency 1 cycle: accept at edge N, rspi_valid high from N+1.
- Throughput: 1 op/cycle total, alternating under contention.
- Buffer i clears on rspi_valid & rspi_ready unless refilled on the same edge; otherwise it holds all fields stable.
- Op semantics: 000 add, 001 sub, 010 and, 011 or, 100 slt (unsigned compare, result 0/1), 101 xor, 111 pass a, 110 illegal → result 0.
  - Add/sub wrap modulo 2^DATA_W with no carry out.
- bcond = (a==b) for every op.
- Ungranted requester must hold valid/op/a/b/tag stable; the block does not latch pending requests.
- Backpressure on one response channel never blocks the other requester.
- Reset mid-operation: buffered results are discarded; no response is issued for a request accepted before reset.

Optional Feature:
- Macro: ALU_ILLEGAL_OP_TRAP_EN.
- Defined:
  - Adds ports rsp0_err and rsp1_err (out, 1), registered alongside result; reset 0.
  - err=1 for op 110, result 0.
- Undefined:
  - No err ports; op 110 silently returns result 0 with normal bcond.

Decomposition:
- Shared package alu_pkg:
  - aluop localparams ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_XOR, ALU_ILL, ALU_PASS.
  - Defaults for DATA_W and TAG_W.
- Sub-module alu_rr_arb2: 2-way round-robin arbiter with eligible[1:0] in, grant[1:0] out, owns the rr_last register.
- Existing ALU module instantiated once.

Test Plan:
- Reset then idle, all valids 0 → req*_ready=0, rsp*_valid=0 for 10 cycles.
- req0 add a=5 b=7 tag=3, rsp0_ready=1 → req0_ready same cycle; next cycle rsp0_valid=1, result=12, bcond=0, tag=3.
- Both valid every cycle, both rsp_ready=1 → grants 0,1,0,1…; first grant to req0 after reset.
- rsp0_ready=0 with buffer 0 full, both valid → req0_ready stays 0, req1 served each cycle; raising rsp0_ready grants req0 same cycle (refill).
- Ops:
  - slt a=0xFFFFFFFF b=1 → 0.
  - sub a=3 b=5 → 0xFFFFFFFE.
  - pass a=0xDEAD → 0xDEAD.
  - xor a=b=0xA5 → 0, bcond=1.
- Op 110 → result 0, rsp_err=1 with ALU_ILLEGAL_OP_TRAP_EN; assert rst while rsp1_valid=1 → rsp1_valid=0 immediately, no stale response after release.
